// File: rtl/banco_registros.sv
// Register file: two combinational read ports, one synchronous write port, R0 reads zero.
// Optional same-cycle write forwarding to the read ports when WRITE_BYPASS_EN is defined.
module banco_registros #(
   parameter int N      = 16,
   parameter int ADDR_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [N-1:0]      wr_data_i,
   input  logic [ADDR_W-1:0] rd_addr_a_i,
   input  logic [ADDR_W-1:0] rd_addr_b_i,
   output logic [N-1:0]      rd_data_a_o,
   output logic [N-1:0]      rd_data_b_o
);

   localparam int NREG = 2**ADDR_W;

   logic [N-1:0] regs_reg [1:NREG-1];
   logic [N-1:0] rd_view  [NREG];
   logic [N-1:0] rd_a_next;
   logic [N-1:0] rd_b_next;
   logic         wr_valid;

   assign wr_valid   = wr_en_i && (wr_addr_i != '0);
   assign rd_view[0] = '0;

   genvar gi;
   generate
      for (gi = 1; gi < NREG; gi++) begin : g_reg
         always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
               regs_reg[gi] <= '0;
            end else if (wr_valid && (wr_addr_i == ADDR_W'(gi))) begin
               regs_reg[gi] <= wr_data_i;
            end
         end
         assign rd_view[gi] = regs_reg[gi];
      end
   endgenerate

   always_comb begin
      rd_a_next = rd_view[rd_addr_a_i];
      rd_b_next = rd_view[rd_addr_b_i];
`ifdef WRITE_BYPASS_EN
      // Forward only real writes; address 0 is excluded by wr_valid.
      if (wr_valid && (rd_addr_a_i == wr_addr_i)) rd_a_next = wr_data_i;
      if (wr_valid && (rd_addr_b_i == wr_addr_i)) rd_b_next = wr_data_i;
`endif
   end

   // Outputs are forced to zero while reset is held, bypass or not.
   assign rd_data_a_o = rst_ni ? rd_a_next : '0;
   assign rd_data_b_o = rst_ni ? rd_b_next : '0;

endmodule

// File: tb/tb_banco_registros.sv
// Directed self-checking bench for banco_registros.
module tb_banco_registros;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        wr_en_i = 1'b0;
   logic [3:0]  wr_addr_i = '0;
   logic [15:0] wr_data_i = '0;
   logic [3:0]  rd_addr_a_i = '0;
   logic [3:0]  rd_addr_b_i = '0;
   logic [15:0] rd_data_a_o;
   logic [15:0] rd_data_b_o;

   int n_checks = 0;
   int n_fail   = 0;

   banco_registros #(.N(16), .ADDR_W(4)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .wr_en_i(wr_en_i), .wr_addr_i(wr_addr_i),
      .wr_data_i(wr_data_i), .rd_addr_a_i(rd_addr_a_i), .rd_addr_b_i(rd_addr_b_i),
      .rd_data_a_o(rd_data_a_o), .rd_data_b_o(rd_data_b_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic do_write(input logic [3:0] addr, input logic [15:0] data);
      @(negedge clk_i);
      wr_en_i = 1'b1; wr_addr_i = addr; wr_data_i = data;
      @(posedge clk_i); #1;
      wr_en_i = 1'b0;
   endtask

   task automatic test_reset();
      do_write(4'd1, 16'h1234);
      do_write(4'd15, 16'hABCD);
      @(negedge clk_i);
      rd_addr_a_i = 4'd15; rd_addr_b_i = 4'd1; #1;
      n_checks++;
      if (rd_data_a_o !== 16'hABCD) begin n_fail++; $display("FAIL pre_reset R15 got %h want ABCD", rd_data_a_o); end
      #1 rst_ni = 1'b0; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h0000 || rd_data_b_o !== 16'h0000) begin
         n_fail++; $display("FAIL async_reset got a=%h b=%h want 0000", rd_data_a_o, rd_data_b_o);
      end
      for (int i = 0; i < 16; i++) begin
         rd_addr_a_i = 4'(i); rd_addr_b_i = 4'(15 - i); #1;
         n_checks++;
         if (rd_data_a_o !== 16'h0000 || rd_data_b_o !== 16'h0000) begin
            n_fail++; $display("FAIL reset_sweep addr=%0d got a=%h b=%h want 0000", i, rd_data_a_o, rd_data_b_o);
         end
      end
      @(negedge clk_i); rst_ni = 1'b1;
      rd_addr_a_i = 4'd15; rd_addr_b_i = 4'd1; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h0000 || rd_data_b_o !== 16'h0000) begin
         n_fail++; $display("FAIL post_reset got a=%h b=%h want 0000", rd_data_a_o, rd_data_b_o);
      end
      $display("test_reset done");
   endtask

   task automatic test_write_read();
      logic [15:0] sra;
      do_write(4'd5, 16'h8001);
      do_write(4'd3, 16'h0004);
      rd_addr_a_i = 4'd5; rd_addr_b_i = 4'd3; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h8001 || rd_data_b_o !== 16'h0004) begin
         n_fail++; $display("FAIL write_read got a=%h b=%h want 8001 0004", rd_data_a_o, rd_data_b_o);
      end
      sra = 16'($signed(rd_data_a_o) >>> rd_data_b_o[3:0]);
      n_checks++;
      if (sra !== 16'hF800) begin n_fail++; $display("FAIL sra_operands got %h want F800", sra); end
      $display("test_write_read a=%h b=%h sra=%h", rd_data_a_o, rd_data_b_o, sra);
   endtask

   task automatic test_r0();
      do_write(4'd0, 16'hFFFF);
      rd_addr_a_i = 4'd0; rd_addr_b_i = 4'd0; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h0000 || rd_data_b_o !== 16'h0000) begin
         n_fail++; $display("FAIL r0_write got a=%h b=%h want 0000", rd_data_a_o, rd_data_b_o);
      end
      rd_addr_a_i = 4'd5; rd_addr_b_i = 4'd3; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h8001 || rd_data_b_o !== 16'h0004) begin
         n_fail++; $display("FAIL r0_others got a=%h b=%h want 8001 0004", rd_data_a_o, rd_data_b_o);
      end
      $display("test_r0 done");
   endtask

   task automatic test_read_during_write();
      logic [15:0] exp_same;
`ifdef WRITE_BYPASS_EN
      exp_same = 16'h2222;
`else
      exp_same = 16'h1111;
`endif
      do_write(4'd7, 16'h1111);
      @(negedge clk_i);
      wr_en_i = 1'b1; wr_addr_i = 4'd7; wr_data_i = 16'h2222;
      rd_addr_a_i = 4'd7; rd_addr_b_i = 4'd5; #1;
      n_checks++;
      if (rd_data_a_o !== exp_same) begin n_fail++; $display("FAIL rdw_same_cycle got %h want %h", rd_data_a_o, exp_same); end
      n_checks++;
      if (rd_data_b_o !== 16'h8001) begin n_fail++; $display("FAIL rdw_other_port got %h want 8001", rd_data_b_o); end
      @(posedge clk_i); #1;
      wr_en_i = 1'b0; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h2222) begin n_fail++; $display("FAIL rdw_after_edge got %h want 2222", rd_data_a_o); end
      // Address 0 writes are never forwarded.
      @(negedge clk_i);
      wr_en_i = 1'b1; wr_addr_i = 4'd0; wr_data_i = 16'h5A5A; rd_addr_a_i = 4'd0; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h0000) begin n_fail++; $display("FAIL rdw_r0 got %h want 0000", rd_data_a_o); end
      @(posedge clk_i); #1 wr_en_i = 1'b0;
      $display("test_read_during_write same=%h", exp_same);
   endtask

   task automatic test_reset_vs_write();
      do_write(4'd2, 16'h00AA);
      @(negedge clk_i);
      wr_en_i = 1'b1; wr_addr_i = 4'd2; wr_data_i = 16'h0055;
      rd_addr_a_i = 4'd2; rd_addr_b_i = 4'd2;
      #3 rst_ni = 1'b0;
      @(posedge clk_i); #1;
      n_checks++;
      if (rd_data_a_o !== 16'h0000) begin n_fail++; $display("FAIL rst_write_held got %h want 0000", rd_data_a_o); end
      @(negedge clk_i);
      wr_en_i = 1'b0; rst_ni = 1'b1; #1;
      n_checks++;
      if (rd_data_a_o !== 16'h0000 || rd_data_b_o !== 16'h0000) begin
         n_fail++; $display("FAIL rst_write_lost got a=%h b=%h want 0000", rd_data_a_o, rd_data_b_o);
      end
      do_write(4'd2, 16'h0055);
      n_checks++;
      if (rd_data_a_o !== 16'h0055) begin n_fail++; $display("FAIL rst_first_write got %h want 0055", rd_data_a_o); end
      $display("test_reset_vs_write done");
   endtask

   task automatic test_disabled_and_sweep();
      logic [15:0] ea, eb;
      do_write(4'd9, 16'h9999);
      @(negedge clk_i);
      wr_en_i = 1'b0; wr_addr_i = 4'd9; wr_data_i = 16'hBEEF; rd_addr_a_i = 4'd9;
      @(posedge clk_i); #1;
      n_checks++;
      if (rd_data_a_o !== 16'h9999) begin n_fail++; $display("FAIL disabled_write got %h want 9999", rd_data_a_o); end
      for (int i = 1; i < 16; i++) do_write(4'(i), 16'(i * 16'h1111));
      for (int i = 0; i < 16; i++) begin
         rd_addr_a_i = 4'(i); rd_addr_b_i = 4'(15 - i); #1;
         ea = 16'(i * 16'h1111);
         eb = 16'((15 - i) * 16'h1111);
         n_checks++;
         if (rd_data_a_o !== ea || rd_data_b_o !== eb) begin
            n_fail++; $display("FAIL sweep i=%0d got a=%h b=%h want %h %h", i, rd_data_a_o, rd_data_b_o, ea, eb);
         end
         $display("sweep a[%0d]=%h b[%0d]=%h", i, rd_data_a_o, 15 - i, rd_data_b_o);
      end
   endtask

   initial begin
      #2 rst_ni = 1'b0;
      #1;
      n_checks++;
      if (rd_data_a_o !== 16'h0000 || rd_data_b_o !== 16'h0000) begin
         n_fail++; $display("FAIL initial_reset got a=%h b=%h want 0000", rd_data_a_o, rd_data_b_o);
      end
      @(negedge clk_i); rst_ni = 1'b1;
      test_reset();
      test_write_read();
      test_r0();
      test_read_during_write();
      test_reset_vs_write();
      test_disabled_and_sweep();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
